// File: rtl/mem_burst_master.sv
// Burst master: host requests become 1..16 single-word memory accesses. Writes issue one access per accepted beat, one cycle later.
// Reads take at least 3 cycles per beat (issue, capture, hold). Rd_Data is held until Rd_Ready; Wr_Ready is only high while collecting write beats.
module mem_burst_master #(
    parameter int WIDTH     = 8,
    parameter int DinLength = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Req_Valid,
    output logic                 Req_Ready,
    input  logic                 Req_RW,
    input  logic [WIDTH-1:0]     Req_Addr,
    input  logic [3:0]           Req_Len,
    input  logic                 Wr_Valid,
    output logic                 Wr_Ready,
    input  logic [DinLength-1:0] Wr_Data,
    output logic                 Rd_Valid,
    input  logic                 Rd_Ready,
    output logic [DinLength-1:0] Rd_Data,
    output logic                 Rd_Last,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Mem_Valid,
    output logic                 Mem_R_W,
    output logic [WIDTH-1:0]     Mem_Addr,
    output logic [DinLength-1:0] Mem_Din,
    input  logic [DinLength-1:0] Mem_Dout
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DATA  = 3'd1,
        RD_ISSUE = 3'd2,
        RD_CAPT  = 3'd3,
        RD_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] addr_inc;
    logic [3:0]       len_q;
    logic [3:0]       cnt_q;
    logic             last_beat;
    logic             req_take;
    logic             wr_take;
    logic             rd_take;

    assign addr_inc  = addr_q + WIDTH'(1);
    assign last_beat = (cnt_q == len_q);
    assign req_take  = (state == IDLE) && Req_Valid;
    assign wr_take   = (state == WR_DATA) && Wr_Valid;
    assign rd_take   = (state == RD_HOLD) && Rd_Ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Req_Valid) begin
                    state_nxt = Req_RW ? WR_DATA : RD_ISSUE;
                end
            end
            WR_DATA: begin
                if (Wr_Valid && last_beat) begin
                    state_nxt = DONE;
                end
            end
            RD_ISSUE: state_nxt = RD_CAPT;
            RD_CAPT:  state_nxt = RD_HOLD;
            RD_HOLD: begin
                if (Rd_Ready) begin
                    state_nxt = last_beat ? DONE : RD_ISSUE;
                end
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Handshake readies are masked by Reset so nothing is accepted on a reset edge.
    always_comb begin
        Req_Ready = (state == IDLE) && !Reset;
        Wr_Ready  = (state == WR_DATA) && !Reset;
        Rd_Valid  = (state == RD_HOLD);
        Rd_Last   = (state == RD_HOLD) && last_beat;
        Busy      = (state != IDLE);
        Done      = (state == DONE);
    end

    // Memory strobe is registered: a write lands the cycle after its beat is
    // accepted, and a read strobe is raised on entry to RD_ISSUE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            Mem_Valid <= 1'b0;
            Mem_R_W   <= 1'b0;
            Mem_Addr  <= '0;
            Mem_Din   <= '0;
            Rd_Data   <= '0;
        end else begin
            Mem_Valid <= 1'b0;
            if (req_take) begin
                addr_q  <= Req_Addr;
                len_q   <= Req_Len;
                cnt_q   <= '0;
                Mem_R_W <= Req_RW;
                if (!Req_RW) begin
                    Mem_Valid <= 1'b1;
                    Mem_Addr  <= Req_Addr;
                end
            end
            if (wr_take) begin
                Mem_Valid <= 1'b1;
                Mem_Addr  <= addr_q;
                Mem_Din   <= Wr_Data;
                addr_q    <= addr_inc;
                cnt_q     <= cnt_q + 4'd1;
            end
            if (rd_take && !last_beat) begin
                Mem_Valid <= 1'b1;
                Mem_Addr  <= addr_inc;
                addr_q    <= addr_inc;
                cnt_q     <= cnt_q + 4'd1;
            end
            if (state == RD_CAPT) begin
                Rd_Data <= Mem_Dout;
            end
        end
    end

    a_mem_valid_states: assert property (@(posedge Clk) disable iff (Reset)
        Mem_Valid |-> (state == WR_DATA || state == RD_ISSUE || state == DONE));
    a_done_pulse: assert property (@(posedge Clk) disable iff (Reset)
        Done |=> !Done);
    a_rd_hold: assert property (@(posedge Clk) disable iff (Reset)
        (Rd_Valid && !Rd_Ready) |=> (Rd_Valid && $stable(Rd_Data)));

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master: a memory model answers strobes, an access
// scoreboard plus per-cycle rule checks run alongside hand-computed burst vectors.
module tb_mem_burst_master;
    localparam int W = 8;
    localparam int D = 32;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Req_Valid;
    logic         Req_Ready;
    logic         Req_RW;
    logic [W-1:0] Req_Addr;
    logic [3:0]   Req_Len;
    logic         Wr_Valid;
    logic         Wr_Ready;
    logic [D-1:0] Wr_Data;
    logic         Rd_Valid;
    logic         Rd_Ready;
    logic [D-1:0] Rd_Data;
    logic         Rd_Last;
    logic         Busy;
    logic         Done;
    logic         Mem_Valid;
    logic         Mem_R_W;
    logic [W-1:0] Mem_Addr;
    logic [D-1:0] Mem_Din;
    logic [D-1:0] Mem_Dout;

    always #5 Clk = ~Clk;

    mem_burst_master #(.WIDTH(W), .DinLength(D)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_RW(Req_RW),
        .Req_Addr(Req_Addr), .Req_Len(Req_Len),
        .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Wr_Data(Wr_Data),
        .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready), .Rd_Data(Rd_Data), .Rd_Last(Rd_Last),
        .Busy(Busy), .Done(Done),
        .Mem_Valid(Mem_Valid), .Mem_R_W(Mem_R_W), .Mem_Addr(Mem_Addr),
        .Mem_Din(Mem_Din), .Mem_Dout(Mem_Dout)
    );

    typedef struct {
        logic [W-1:0] addr;
        logic         rw;
        logic [D-1:0] dat;
    } acc_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           done_cnt = 0;
    int           mv_cnt = 0;
    int           last_rd_cyc = 0;
    acc_t         exp_q[$];
    acc_t         e;
    logic [D-1:0] phys_mem [256];
    logic [D-1:0] ref_mem [256];
    logic [D-1:0] got [16];
    logic [W-1:0] p_addr;
    logic [D-1:0] p_din;
    logic [D-1:0] p_rdata;
    logic         p_rvld;
    logic         p_rrdy;
    logic         p_rst;
    logic         p_ok = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Memory: writes land at the strobe edge, read data appears the next cycle.
    always @(posedge Clk) begin
        if (Mem_Valid && Mem_R_W) phys_mem[Mem_Addr] <= Mem_Din;
        if (Mem_Valid && !Mem_R_W) Mem_Dout <= phys_mem[Mem_Addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge Clk);
        if (!Reset) begin
            check("busy_vs_ready", 64'(Busy), 64'(!Req_Ready));
            if (Done) done_cnt++;
            if (Mem_Valid) begin
                mv_cnt++;
                if (!Mem_R_W) last_rd_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_access: got addr %0h rw %0b expected no access", Mem_Addr, Mem_R_W);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_addr", 64'(Mem_Addr), 64'(e.addr));
                    check("acc_rw", 64'(Mem_R_W), 64'(e.rw));
                    if (e.rw) check("acc_data", 64'(Mem_Din), 64'(e.dat));
                end
            end else if (p_ok && !p_rst) begin
                check("addr_hold", 64'(Mem_Addr), 64'(p_addr));
                check("din_hold", 64'(Mem_Din), 64'(p_din));
            end
            if (p_ok && !p_rst && p_rvld && !p_rrdy) begin
                check("rd_stay_valid", 64'(Rd_Valid), 64'd1);
                check("rd_stable", 64'(Rd_Data), 64'(p_rdata));
            end
        end
        p_addr  = Mem_Addr;
        p_din   = Mem_Din;
        p_rdata = Rd_Data;
        p_rvld  = Rd_Valid;
        p_rrdy  = Rd_Ready;
        p_rst   = Reset;
        p_ok    = 1'b1;
    end

    task automatic wr_burst(input logic [W-1:0] a, input logic [3:0] len,
                            input logic [D-1:0] base, input logic inject);
        int mv0 = mv_cnt;
        int dn0 = done_cnt;
        for (int i = 0; i <= int'(len); i++) begin
            logic [W-1:0] ai = a + W'(i);
            exp_q.push_back('{addr: ai, rw: 1'b1, dat: base + D'(i)});
            ref_mem[ai] = base + D'(i);
        end
        @(posedge Clk); #1;
        Req_Valid = 1'b1; Req_RW = 1'b1; Req_Addr = a; Req_Len = len;
        @(negedge Clk);
        check("wr_req_ready", 64'(Req_Ready), 64'd1);
        for (int i = 0; i <= int'(len); i++) begin
            @(posedge Clk); #1;
            Req_Valid = inject && (i == 1);
            if (inject) begin
                Req_RW = 1'b0; Req_Addr = 8'h99;
            end
            Wr_Valid = 1'b1;
            Wr_Data  = base + D'(i);
            @(negedge Clk);
            check("wr_ready", 64'(Wr_Ready), 64'd1);
            if (i > 0) check("wr_b2b_valid", 64'(Mem_Valid), 64'd1);
        end
        @(posedge Clk); #1;
        Wr_Valid = 1'b0; Req_Valid = 1'b0;
        @(negedge Clk);
        check("wr_last_valid", 64'(Mem_Valid), 64'd1);
        check("wr_done", 64'(Done), 64'd1);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("wr_idle", 64'(Busy), 64'd0);
        check("wr_pulses", 64'(mv_cnt - mv0), 64'(int'(len) + 1));
        check("wr_done_cnt", 64'(done_cnt - dn0), 64'd1);
    endtask

    task automatic rd_burst(input logic [W-1:0] a, input logic [3:0] len,
                            input int hold_beat, input int hold_n, input int rst_beat);
        int dn0 = done_cnt;
        for (int i = 0; i <= int'(len); i++)
            exp_q.push_back('{addr: a + W'(i), rw: 1'b0, dat: '0});
        @(posedge Clk); #1;
        Req_Valid = 1'b1; Req_RW = 1'b0; Req_Addr = a; Req_Len = len; Rd_Ready = 1'b0;
        @(negedge Clk);
        check("rd_req_ready", 64'(Req_Ready), 64'd1);
        @(posedge Clk); #1;
        Req_Valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            logic [W-1:0] ai = a + W'(i);
            int n = 0;
            @(negedge Clk);
            while (!Rd_Valid && n < 10) begin
                @(negedge Clk);
                n++;
            end
            if (!Rd_Valid) begin
                check("rd_timeout", 64'd0, 64'd1);
                exp_q.delete();
                return;
            end
            got[i] = Rd_Data;
            check("rd_latency", 64'(cyc - last_rd_cyc), 64'd2);
            check("rd_data", 64'(Rd_Data), 64'(ref_mem[ai]));
            check("rd_last", 64'(Rd_Last), 64'(i == int'(len)));
            if (i == rst_beat) begin
                @(posedge Clk); #1;
                Reset = 1'b1;
                @(negedge Clk);
                check("rst_req_ready", 64'(Req_Ready), 64'd0);
                check("rst_wr_ready", 64'(Wr_Ready), 64'd0);
                @(posedge Clk); #1;
                Reset = 1'b0;
                @(negedge Clk);
                check("rst_outs", 64'({Mem_Valid, Mem_R_W, Mem_Addr, Rd_Valid, Rd_Last, Busy, Done}), 64'd0);
                check("rst_din", 64'(Mem_Din), 64'd0);
                check("rst_rdata", 64'(Rd_Data), 64'd0);
                check("rst_ready_after", 64'(Req_Ready), 64'd1);
                exp_q.delete();
                return;
            end
            for (int k = 1; k < ((i == hold_beat) ? hold_n : 1); k++) begin
                @(posedge Clk); #1;
                @(negedge Clk);
                check("hold_valid", 64'(Rd_Valid), 64'd1);
                check("hold_data", 64'(Rd_Data), 64'(ref_mem[ai]));
                check("hold_no_mem", 64'(Mem_Valid), 64'd0);
            end
            @(posedge Clk); #1;
            Rd_Ready = 1'b1;
            @(posedge Clk); #1;
            Rd_Ready = 1'b0;
        end
        @(negedge Clk);
        check("rd_done", 64'(Done), 64'd1);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("rd_idle", 64'(Busy), 64'd0);
        check("rd_done_cnt", 64'(done_cnt - dn0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int mv0;
        int dn0;
        Reset = 1'b1; Req_Valid = 1'b0; Req_RW = 1'b0; Req_Addr = '0; Req_Len = '0;
        Wr_Valid = 1'b0; Wr_Data = '0; Rd_Ready = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_req_ready", 64'(Req_Ready), 64'd0);
        check("reset_wr_ready", 64'(Wr_Ready), 64'd0);
        check("reset_outs", 64'({Mem_Valid, Mem_R_W, Mem_Addr, Rd_Valid, Rd_Last, Busy, Done}), 64'd0);
        check("reset_din", 64'(Mem_Din), 64'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("post_reset_ready", 64'(Req_Ready), 64'd1);

        wr_burst(8'h10, 4'd0, 32'hDEADBEEF, 1'b0);
        check("single_addr_held", 64'(Mem_Addr), 64'h10);
        check("single_din_held", 64'(Mem_Din), 64'hDEADBEEF);

        wr_burst(8'hFE, 4'd3, 32'd1, 1'b0);
        check("wrap_mem_ff", 64'(phys_mem[8'hFF]), 64'd2);
        check("wrap_mem_01", 64'(phys_mem[8'h01]), 64'd4);

        // Stray write beats and read acks while idle must do nothing.
        mv0 = mv_cnt;
        @(posedge Clk); #1;
        Wr_Valid = 1'b1; Wr_Data = 32'h0BAD0BAD; Rd_Ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Wr_Valid = 1'b0; Rd_Ready = 1'b0;
        @(negedge Clk);
        check("stray_busy", 64'(Busy), 64'd0);
        check("stray_no_access", 64'(mv_cnt - mv0), 64'd0);

        wr_burst(8'h20, 4'd3, 32'hCAFE0000, 1'b0);
        rd_burst(8'h20, 4'd2, 1, 5, -1);
        check("rd_beat_a", 64'(got[0]), 64'hCAFE0000);
        check("rd_beat_b", 64'(got[1]), 64'hCAFE0001);
        check("rd_beat_c", 64'(got[2]), 64'hCAFE0002);

        rd_burst(8'hFE, 4'd1, -1, 0, -1);
        check("rd_wrap_fe", 64'(got[0]), 64'd1);
        check("rd_wrap_ff", 64'(got[1]), 64'd2);

        wr_burst(8'h40, 4'd3, 32'h00005000, 1'b1);
        check("reject_mem_43", 64'(phys_mem[8'h43]), 64'h5003);

        rd_burst(8'h20, 4'd3, -1, 0, 1);
        mv0 = mv_cnt;
        dn0 = done_cnt;
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        check("abort_no_access", 64'(mv_cnt - mv0), 64'd0);
        check("abort_no_done", 64'(done_cnt - dn0), 64'd0);
        check("abort_idle_ready", 64'(Req_Ready), 64'd1);

        wr_burst(8'h00, 4'd15, 32'h00000100, 1'b0);
        check("max_mem_0f", 64'(phys_mem[8'h0F]), 64'h10F);

        rd_burst(8'h0E, 4'd2, -1, 0, -1);
        check("rdback_0e", 64'(got[0]), 64'h10E);
        check("rdback_10", 64'(got[2]), 64'hDEADBEEF);

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
